// File: rtl/fft_address_gen.sv
// Address and control sequencer for an in-place radix-2 DIT FFT.
// Each RUN cycle issues one butterfly read: the operand pair and its
// twiddle index. The same address pair comes back out as a write-back
// strobe WB_LAT non-stalled cycles later. A DRAIN phase between stages
// lets the last write of a stage land before the next stage reads.
module fft_address_gen #(
  parameter int LOG2N  = 4,
  parameter int WB_LAT = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] twiddle_idx,
  output logic [2:0]       stage,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int              KW         = LOG2N - 1;
  localparam logic [KW-1:0]   K_LAST     = '1;
  localparam logic [2:0]      STAGE_LAST = 3'(LOG2N - 1);
  localparam logic [2:0]      DRAIN_LAST = 3'(WB_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k;
  logic [2:0]      stage_q;
  logic [2:0]      drain_cnt;

  logic [KW-1:0]    pos_mask, pos_k, grp_k, tw_calc;
  logic [LOG2N-1:0] half_calc, addr_a_calc, addr_b_calc;

  logic             vld_p    [WB_LAT];
  logic [LOG2N-1:0] addr_a_p [WB_LAT];
  logic [LOG2N-1:0] addr_b_p [WB_LAT];

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: stall freezes RUN and DRAIN, DONE is always a single cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (!stall && k == K_LAST) state_d = DRAIN;
      DRAIN: if (!stall && drain_cnt == DRAIN_LAST)
               state_d = (stage_q != STAGE_LAST) ? RUN : DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly index, stage and drain counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      k         <= '0;
      stage_q   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          k         <= '0;
          stage_q   <= '0;
          drain_cnt <= '0;
        end
        RUN: if (!stall) begin
          // k wraps to zero after the last butterfly because N/2-1 is all ones
          k         <= k + 1'b1;
          drain_cnt <= '0;
        end
        DRAIN: if (!stall) begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            k         <= '0;
            if (stage_q != STAGE_LAST) stage_q <= stage_q + 3'd1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE: stage_q <= '0;
        default: ;
      endcase
    end
  end

  // Operand addresses: pos = k mod half, grp = k / half, twiddle = pos * N/(2*half)
  always_comb begin
    pos_mask    = ~({KW{1'b1}} << stage_q);
    pos_k       = k & pos_mask;
    grp_k       = k >> stage_q;
    half_calc   = {{KW{1'b0}}, 1'b1} << stage_q;
    addr_a_calc = ({1'b0, grp_k} << ({1'b0, stage_q} + 4'd1)) | {1'b0, pos_k};
    addr_b_calc = addr_a_calc | half_calc;
    tw_calc     = pos_k << (STAGE_LAST - stage_q);
  end

  // Write-back valid pipeline, cleared on reset so an aborted pass writes nothing
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < WB_LAT; i++) vld_p[i] <= 1'b0;
    end else if (!stall) begin
      vld_p[0] <= rd_en;
      for (int i = 1; i < WB_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Write-back address pipeline, only meaningful where the matching valid is set
  always_ff @(posedge clk) begin
    if (!stall) begin
      addr_a_p[0] <= addr_a_calc;
      addr_b_p[0] <= addr_b_calc;
      for (int i = 1; i < WB_LAT; i++) begin
        addr_a_p[i] <= addr_a_p[i-1];
        addr_b_p[i] <= addr_b_p[i-1];
      end
    end
  end

  // Outputs: addresses are forced to zero outside their valid windows
  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    rd_en       = (state_q == RUN) && !stall;
    rd_addr_a   = (state_q == RUN) ? addr_a_calc : '0;
    rd_addr_b   = (state_q == RUN) ? addr_b_calc : '0;
    twiddle_idx = (state_q == RUN) ? tw_calc : '0;
    stage       = stage_q;
    wr_en       = vld_p[WB_LAT-1] && !stall;
    wr_addr_a   = vld_p[WB_LAT-1] ? addr_a_p[WB_LAT-1] : '0;
    wr_addr_b   = vld_p[WB_LAT-1] ? addr_b_p[WB_LAT-1] : '0;
  end

endmodule

// File: tb/tb_fft_address_gen.sv
// Self-checking bench for fft_address_gen (N=16, WB_LAT=2).
// The expected timeline is built from the pass structure: LOG2N stages,
// each made of N/2 issue slots and WB_LAT drain slots. Every slot consumes
// the next non-stalled cycle, and each write lands WB_LAT non-stalled
// cycles after its read.
module tb_fft_address_gen;
  localparam int LOG2N  = 4;
  localparam int WB_LAT = 2;
  localparam int N      = 1 << LOG2N;
  localparam int MAXC   = 200;

  logic       clk = 1'b0;
  logic       n_rst, start, stall;
  logic       busy, done, rd_en, wr_en;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] twiddle_idx;
  logic [2:0] stage;

  always #5 clk = ~clk;

  fft_address_gen #(.LOG2N(LOG2N), .WB_LAT(WB_LAT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .twiddle_idx(twiddle_idx),
    .stage(stage), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  int tests = 0;
  int fails = 0;

  bit stall_s [MAXC];
  bit start_s [MAXC];
  bit e_rd [MAXC], e_wr [MAXC], e_done [MAXC], e_busy [MAXC];
  int e_ra [MAXC], e_rb [MAXC], e_tw [MAXC], e_st [MAXC], e_wa [MAXC], e_wb [MAXC];
  int o_ra [MAXC], o_rb [MAXC], o_tw [MAXC], o_st [MAXC];
  bit o_rd [MAXC];
  int model_done, obs_done, n_wr_seen, n_done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      stall_s[i] = 1'b0;
      start_s[i] = 1'b0;
    end
  endtask

  // Expected timeline for a pass whose start pulse is seen in cycle s0
  task automatic build_model(input int s0);
    int c, w, n, half, pos, grp, a, b;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_done[i] = 0; e_busy[i] = 0;
      e_ra[i] = 0; e_rb[i] = 0; e_tw[i] = 0; e_st[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
    end
    c = s0 + 1;
    for (int s = 0; s < LOG2N; s++) begin
      half = 2 ** s;
      for (int k = 0; k < N / 2; k++) begin
        while (c < MAXC - 1 && stall_s[c]) c++;
        pos = k % half;
        grp = k / half;
        a   = grp * 2 * half + pos;
        b   = a + half;
        e_rd[c] = 1; e_ra[c] = a; e_rb[c] = b; e_st[c] = s;
        e_tw[c] = pos * ((N / 2) / half);
        w = c; n = 0;
        while (n < WB_LAT && w < MAXC - 1) begin
          w++;
          if (!stall_s[w]) n++;
        end
        e_wr[w] = 1; e_wa[w] = a; e_wb[w] = b;
        c++;
      end
      for (int d = 0; d < WB_LAT; d++) begin
        while (c < MAXC - 1 && stall_s[c]) c++;
        c++;
      end
    end
    e_done[c] = 1;
    for (int i = s0 + 1; i <= c; i++) e_busy[i] = 1;
    model_done = c;
  endtask

  // Drive cycles [from..to] from the stimulus tables and compare against the model
  task automatic run_cycles(input int from, input int to);
    n_wr_seen = 0; n_done_seen = 0; obs_done = -1;
    for (int c = from; c <= to; c++) begin
      stall = stall_s[c];
      start = start_s[c];
      #1;
      o_rd[c] = rd_en; o_ra[c] = int'(rd_addr_a); o_rb[c] = int'(rd_addr_b);
      o_tw[c] = int'(twiddle_idx); o_st[c] = int'(stage);
      chk($sformatf("rd_en@%0d", c), rd_en, e_rd[c]);
      if (e_rd[c]) begin
        chk($sformatf("rd_addr_a@%0d", c), rd_addr_a, e_ra[c]);
        chk($sformatf("rd_addr_b@%0d", c), rd_addr_b, e_rb[c]);
        chk($sformatf("twiddle@%0d", c), twiddle_idx, e_tw[c]);
        chk($sformatf("stage@%0d", c), stage, e_st[c]);
      end
      chk($sformatf("wr_en@%0d", c), wr_en, e_wr[c]);
      if (e_wr[c]) begin
        chk($sformatf("wr_addr_a@%0d", c), wr_addr_a, e_wa[c]);
        chk($sformatf("wr_addr_b@%0d", c), wr_addr_b, e_wb[c]);
      end
      chk($sformatf("done@%0d", c), done, e_done[c]);
      chk($sformatf("busy@%0d", c), busy, e_busy[c]);
      if (wr_en === 1'b1) n_wr_seen++;
      if (done === 1'b1) begin
        n_done_seen++;
        obs_done = c;
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_a"}, rd_addr_a, 0);
    chk({tag, "_rd_b"}, rd_addr_b, 0);
    chk({tag, "_tw"}, twiddle_idx, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_wr_a"}, wr_addr_a, 0);
    chk({tag, "_wr_b"}, wr_addr_b, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Plain pass: timing, address triples, write-back count
    clear_stim();
    start_s[0] = 1;
    build_model(0);
    run_cycles(0, model_done + 3);
    chk("nostall_done_cycle", obs_done, 41);
    chk("nostall_done_count", n_done_seen, 1);
    chk("nostall_writes", n_wr_seen, 32);
    chk("s0k0_a", o_ra[1], 0);  chk("s0k0_b", o_rb[1], 1);  chk("s0k0_tw", o_tw[1], 0);
    chk("s1k1_a", o_ra[12], 1); chk("s1k1_b", o_rb[12], 3); chk("s1k1_tw", o_tw[12], 4);
    chk("s2k5_a", o_ra[26], 9); chk("s2k5_b", o_rb[26], 13); chk("s2k5_tw", o_tw[26], 2);
    chk("s3k5_a", o_ra[36], 5); chk("s3k5_b", o_rb[36], 13); chk("s3k5_tw", o_tw[36], 5);
    chk("rd_gap_9", o_rd[9], 0);
    chk("rd_last_38", o_rd[38], 1);

    // Three-cycle stall at stage 1, k=4
    clear_stim();
    start_s[0] = 1;
    stall_s[15] = 1; stall_s[16] = 1; stall_s[17] = 1;
    build_model(0);
    run_cycles(0, model_done + 3);
    chk("stall_done_cycle", obs_done, 44);
    chk("stall_writes", n_wr_seen, 32);
    chk("stall_rd15", o_rd[15], 0);
    chk("stall_rd17", o_rd[17], 0);
    chk("stall_resume_a", o_ra[18], 8);
    chk("stall_resume_b", o_rb[18], 10);
    chk("stall_resume_st", o_st[18], 1);

    // Start pulses during a pass are ignored
    clear_stim();
    start_s[0] = 1; start_s[5] = 1; start_s[20] = 1;
    build_model(0);
    run_cycles(0, model_done + 3);
    chk("restart_done_cycle", obs_done, 41);
    chk("restart_done_count", n_done_seen, 1);
    chk("restart_writes", n_wr_seen, 32);

    // Reset in the middle of a pass
    clear_stim();
    start_s[0] = 1;
    build_model(0);
    run_cycles(0, 14);
    n_rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all_zero($sformatf("inreset%0d", i));
    end
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all_zero($sformatf("postreset%0d", i));
    end
    clear_stim();
    start_s[0] = 1;
    build_model(0);
    run_cycles(0, model_done + 3);
    chk("fresh_a", o_ra[1], 0);
    chk("fresh_b", o_rb[1], 1);
    chk("fresh_tw", o_tw[1], 0);
    chk("fresh_stage", o_st[1], 0);
    chk("fresh_done_cycle", obs_done, 41);

    // Random stall patterns (including stall with start) and stray start pulses
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      start_s[0] = 1;
      for (int c = 0; c < MAXC - 60; c++) stall_s[c] = ($urandom_range(0, 3) == 0);
      for (int c = 1; c < 30; c++) start_s[c] = ($urandom_range(0, 15) == 0);
      build_model(0);
      run_cycles(0, model_done + 3);
      chk($sformatf("rand%0d_done_cycle", r), obs_done, model_done);
      chk($sformatf("rand%0d_done_count", r), n_done_seen, 1);
      chk($sformatf("rand%0d_writes", r), n_wr_seen, 32);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_address_gen.md
FFT_ADDRESS_GEN -- requirements
Module: fft_address_gen

Interface
REQ-001 The block SHALL have parameter LOG2N, default 4, giving log2 of FFT points (N = 2^LOG2N, legal 2..8).
REQ-002 The block SHALL have parameter WB_LAT, default 2, giving cycles from read issue to write-back (memory read plus butterfly_block plus register), legal 1..4.
REQ-003 The block SHALL have the port clk, in, 1, the single system clock (rising edge).
REQ-004 The block SHALL have the port n_rst, in, 1, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have the port start, in, 1, a one-cycle request to run a full FFT pass.
REQ-006 The block SHALL have the port stall, in, 1, which freezes issue, counters and the write pipeline while high.
REQ-007 The block SHALL have the port busy, out, 1, high from the first issue cycle through the done cycle.
REQ-008 The block SHALL have the port done, out, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have the port rd_en, out, 1, which reads the butterfly operand pair this cycle.
REQ-010 The block SHALL have the ports rd_addr_a and rd_addr_b, out, LOG2N each, the sample RAM addresses for butterfly input_1 and input_2.
REQ-011 The block SHALL have the port twiddle_idx, out, LOG2N-1, the twiddle ROM index aligned with rd_en.
REQ-012 The block SHALL have the port stage, out, 3, the current stage number.
REQ-013 The block SHALL have the port wr_en, out, 1, which writes butterfly output_1/output_2 back.
REQ-014 The block SHALL have the ports wr_addr_a and wr_addr_b, out, LOG2N each, the write-back addresses for output_1 and output_2.

Function
REQ-015 The block SHALL implement states IDLE, RUN, DRAIN and DONE with one-hot or binary encoding chosen freely.
REQ-016 In IDLE, start=1 SHALL load stage=0 and k=0 and enter RUN on the next edge; start while not IDLE SHALL be ignored.
REQ-017 In RUN with stall=0, the block SHALL assert rd_en=1 for exactly one butterfly per cycle and increment k.
REQ-018 With half=2^stage, pos=k mod half and grp=k>>stage, the addresses SHALL be rd_addr_a=grp*2*half+pos, rd_addr_b=rd_addr_a+half, and twiddle_idx=pos<<(LOG2N-1-stage) (radix-2 in-place DIT, with input preloaded bit-reversed).
REQ-019 After issuing k=N/2-1, the block SHALL go to DRAIN and hold DRAIN for WB_LAT non-stalled cycles.
REQ-020 At the end of DRAIN, the block SHALL increment stage, clear k and re-enter RUN if stage<LOG2N-1; otherwise it SHALL go to DONE.
REQ-021 DONE SHALL last one cycle, assert done=1 and busy=1, then return to IDLE.
REQ-022 The write pipeline SHALL be a WB_LAT-deep shift register of {valid, addr_a, addr_b}: an issue at cycle t SHALL produce wr_en=1 with the same addresses at cycle t+WB_LAT.
REQ-023 When stall=1, the FSM, k, the drain counter and the write pipeline SHALL hold; rd_en and wr_en SHALL be 0 that cycle; address outputs MAY hold.
REQ-024 The next stage's first read SHALL never precede the previous stage's last write (guaranteed by DRAIN).
REQ-025 Without stalls, the block SHALL take LOG2N*(N/2+WB_LAT) cycles from the first issue to the last DRAIN cycle, followed by the DONE cycle.
REQ-026 start and stall asserted simultaneously in IDLE SHALL still accept start; the first issue SHALL wait for stall=0.

Reset
REQ-027 While n_rst=0 (asynchronously), the block SHALL hold state=IDLE, k=0, stage=0, all pipeline valid bits=0, and all outputs 0.
REQ-028 Reset asserted mid-pass SHALL abort immediately with no further rd_en or wr_en and no done pulse; start after release SHALL begin a fresh pass at stage 0.

Verification
REQ-029 The bench SHALL check the no-stall timing: with N=16, WB_LAT=2 and start at cycle 0, rd_en SHALL be high at cycles 1-8, 11-18, 21-28 and 31-38, done SHALL pulse at cycle 41, and busy SHALL be high for cycles 1-41.
REQ-030 The bench SHALL check these address triples (rd_addr_a, rd_addr_b, twiddle_idx): stage0 k0 (0,1,0); stage1 k1 (1,3,4); stage2 k5 (9,13,2); stage3 k5 (5,13,5).
REQ-031 The bench SHALL check write-back: each wr_en SHALL occur exactly 2 cycles after its rd_en with identical addresses, and 32 writes in total SHALL occur per pass.
REQ-032 The bench SHALL check stall: stall=1 for 3 cycles during stage1 k=4 SHALL give no rd_en/wr_en in those cycles, resume at k=4, and delay done by exactly 3 cycles.
REQ-033 The bench SHALL check reset mid-pass: n_rst=0 at cycle 15 SHALL drive all outputs 0 at once with no done; start after release SHALL restart at stage 0 with addresses (0,1,0).
REQ-034 The bench SHALL check that start pulses at cycles 5 and 20 during a pass are ignored, giving exactly one done pulse at cycle 41.
